// File: rtl/stream_out_shell.sv
`default_nettype none
// ============================================================================
// Module   : stream_out_shell
// Purpose  : Output-side stream shell. Accepts fire-and-forget operator writes
//            into a block-RAM FIFO and presents them downstream through a
//            registered val_out / ready_downward handshake. almost_full gives
//            the operator early backpressure so in-flight words are not lost.
// Ports    : clk, reset          - single clock, synchronous active-high reset
//            din, wr_en          - operator write port (no per-beat stall)
//            almost_full, full   - registered occupancy flags
//            dout, val_out       - downstream word (zero while val_out=0)
//            ready_downward      - downstream accept
//            count               - words in RAM + read in flight + presented
//            overflow_err        - sticky, set by a write dropped while full
// Revision : 1.0 - initial release
// ============================================================================
module stream_out_shell #(
   parameter int PAYLOAD_BITS       = 128,
   parameter int NUM_BRAM_ADDR_BITS = 7,
   parameter int ALMOST_FULL_MARGIN = 4    // must be < 2**NUM_BRAM_ADDR_BITS
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [PAYLOAD_BITS-1:0]       din,
   input  logic                          wr_en,
   output logic                          almost_full,
   output logic                          full,
   output logic [PAYLOAD_BITS-1:0]       dout,
   output logic                          val_out,
   input  logic                          ready_downward,
   output logic [NUM_BRAM_ADDR_BITS:0]   count,
   output logic                          overflow_err
);

   localparam int c_depth = 2 ** NUM_BRAM_ADDR_BITS;
   localparam logic [NUM_BRAM_ADDR_BITS:0] c_depth_v =
      (NUM_BRAM_ADDR_BITS+1)'(c_depth);
   // almost_full when DEPTH - count <= MARGIN, i.e. count >= DEPTH - MARGIN
   localparam logic [NUM_BRAM_ADDR_BITS:0] c_af_level =
      (NUM_BRAM_ADDR_BITS+1)'(c_depth - ALMOST_FULL_MARGIN);
   localparam logic [NUM_BRAM_ADDR_BITS:0]   c_cnt_one = 1;
   localparam logic [NUM_BRAM_ADDR_BITS-1:0] c_ptr_one = 1;

   typedef enum logic [0:0] {
      ST_NODATA  = 1'b0,
      ST_VALDATA = 1'b1
   } state_t;

   // Block RAM and its output register (the output register is dout itself)
   logic [PAYLOAD_BITS-1:0]        r_mem [c_depth];
   logic [PAYLOAD_BITS-1:0]        r_rd_data;

   logic [NUM_BRAM_ADDR_BITS-1:0]  r_wr_ptr;
   logic [NUM_BRAM_ADDR_BITS-1:0]  r_rd_ptr;
   logic [NUM_BRAM_ADDR_BITS:0]    r_ram_cnt;   // written but not yet read
   logic [NUM_BRAM_ADDR_BITS:0]    r_count;     // total occupancy
   state_t                         r_state;
   logic                           r_val;
   logic                           r_full;
   logic                           r_af;
   logic                           r_ovf;

   logic                           w_wr_acc;
   logic                           w_xfer;
   logic                           w_ram_has;
   logic                           w_rd_issue;
   logic [NUM_BRAM_ADDR_BITS:0]    w_count_nxt;
   logic [NUM_BRAM_ADDR_BITS:0]    w_ram_cnt_nxt;

   always_comb begin
      // full is the registered flag, so a write on the edge that also
      // transfers a word out is still dropped when the shell was full
      w_wr_acc   = wr_en & ~r_full;
      w_xfer     = r_val & ready_downward;
      w_ram_has  = (r_ram_cnt != '0);
      // NODATA always fetches if a word waits; VALDATA only refetches when the
      // presented word leaves on this edge
      w_rd_issue = w_ram_has & ((r_state == ST_NODATA) | ready_downward);

      w_count_nxt = r_count;
      if (w_wr_acc && !w_xfer)
         w_count_nxt = r_count + c_cnt_one;
      else if (!w_wr_acc && w_xfer)
         w_count_nxt = r_count - c_cnt_one;

      w_ram_cnt_nxt = r_ram_cnt;
      if (w_wr_acc && !w_rd_issue)
         w_ram_cnt_nxt = r_ram_cnt + c_cnt_one;
      else if (!w_wr_acc && w_rd_issue)
         w_ram_cnt_nxt = r_ram_cnt - c_cnt_one;
   end

   // Simple dual-port RAM, 1-cycle read latency. A slot is only read once
   // r_ram_cnt shows it written, so same-address read/write never collide.
   always_ff @(posedge clk) begin
      if (w_wr_acc)
         r_mem[r_wr_ptr] <= din;
      if (w_rd_issue)
         r_rd_data <= r_mem[r_rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_NODATA;
         r_val     <= 1'b0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_ram_cnt <= '0;
         r_count   <= '0;
         r_full    <= 1'b0;
         r_af      <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         if (w_wr_acc)
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
         if (w_rd_issue)
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         r_ram_cnt <= w_ram_cnt_nxt;
         r_count   <= w_count_nxt;
         r_full    <= (w_count_nxt == c_depth_v);
         r_af      <= (w_count_nxt >= c_af_level);
         if (wr_en && r_full)
            r_ovf <= 1'b1;

         case (r_state)
            ST_NODATA: begin
               if (w_ram_has) begin
                  r_state <= ST_VALDATA;
                  r_val   <= 1'b1;
               end
            end
            ST_VALDATA: begin
               // With ready low everything holds; with ready high and a word
               // waiting the refetch keeps us in VALDATA for 1 word/cycle.
               if (ready_downward && !w_ram_has) begin
                  r_state <= ST_NODATA;
                  r_val   <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_NODATA;
               r_val   <= 1'b0;
            end
         endcase
      end
   end

   assign dout         = r_val ? r_rd_data : '0;
   assign val_out      = r_val;
   assign full         = r_full;
   assign almost_full  = r_af;
   assign count        = r_count;
   assign overflow_err = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_stream_out_shell.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_out_shell
// Purpose  : Self-checking bench for stream_out_shell. A scoreboard queue holds
//            every accepted word; words are popped and compared as they
//            transfer downstream. A small occupancy model tracks count, flags
//            and the sticky overflow bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_out_shell;

   localparam int PB     = 128;
   localparam int AW     = 7;
   localparam int DEPTH  = 128;
   localparam int MARGIN = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [PB-1:0] din;
   logic          wr_en;
   logic          almost_full;
   logic          full;
   logic [PB-1:0] dout;
   logic          val_out;
   logic          ready_downward;
   logic [AW:0]   count;
   logic          overflow_err;

   stream_out_shell #(
      .PAYLOAD_BITS       (PB),
      .NUM_BRAM_ADDR_BITS (AW),
      .ALMOST_FULL_MARGIN (MARGIN)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .din            (din),
      .wr_en          (wr_en),
      .almost_full    (almost_full),
      .full           (full),
      .dout           (dout),
      .val_out        (val_out),
      .ready_downward (ready_downward),
      .count          (count),
      .overflow_err   (overflow_err)
   );

   always #5 clk = ~clk;

   int            n_vec = 0;
   int            n_err = 0;
   int            n_pop = 0;
   logic [PB-1:0] last_pop;
   logic [PB-1:0] sb[$];
   int            m_count = 0;
   logic          m_ovf   = 1'b0;
   logic          m_hold  = 1'b0;
   logic [PB-1:0] m_hold_data;

   // One clock cycle: drive inputs, check pre-edge state against the model,
   // then advance to 1 ns after the rising edge.
   task automatic step(input logic w, input logic [PB-1:0] d, input logic rdy);
      logic          acc;
      logic          xfer;
      logic [PB-1:0] exp_word;
      wr_en = w;
      din = d;
      ready_downward = rdy;
      n_vec++;
      if (count !== m_count || full !== (m_count == DEPTH) ||
          almost_full !== ((DEPTH - m_count) <= MARGIN) || overflow_err !== m_ovf) begin
         n_err++;
         $display("FAIL status: count=%0d full=%b af=%b ovf=%b, expected count=%0d full=%b af=%b ovf=%b",
                  count, full, almost_full, overflow_err, m_count, (m_count == DEPTH),
                  ((DEPTH - m_count) <= MARGIN), m_ovf);
      end
      if (!val_out && dout !== '0) begin
         n_vec++;
         n_err++;
         $display("FAIL dout_idle: dout=%0h while val_out=0, expected 0", dout);
      end
      if (m_hold) begin
         n_vec++;
         if (val_out !== 1'b1 || dout !== m_hold_data) begin
            n_err++;
            $display("FAIL hold_stable: val_out=%b dout=%0h, expected val_out=1 dout=%0h",
                     val_out, dout, m_hold_data);
         end
      end
      acc  = w && (m_count != DEPTH);
      xfer = (val_out === 1'b1) && rdy;
      if (xfer) begin
         n_vec++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_word: dout=%0h with empty scoreboard", dout);
         end else begin
            exp_word = sb.pop_front();
            n_pop++;
            last_pop = dout;
            if (dout !== exp_word) begin
               n_err++;
               $display("FAIL data_order: dout=%0h, expected %0h", dout, exp_word);
            end
         end
      end
      if (w && m_count == DEPTH)
         m_ovf = 1'b1;
      if (acc)
         sb.push_back(d);
      m_count = m_count + (acc ? 1 : 0) - (xfer ? 1 : 0);
      m_hold = (val_out === 1'b1) && !rdy;
      m_hold_data = dout;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic rdy);
      reset = 1'b1;
      wr_en = 1'b0;
      din = '0;
      ready_downward = rdy;
      @(posedge clk);
      #1;
      reset = 1'b0;
      sb.delete();
      m_count = 0;
      m_ovf = 1'b0;
      m_hold = 1'b0;
   endtask

   task automatic drain();
      int cyc = 0;
      while ((sb.size() != 0 || val_out !== 1'b0) && cyc < 400) begin
         step(1'b0, '0, 1'b1);
         cyc++;
      end
      n_vec++;
      if (sb.size() != 0 || val_out !== 1'b0 || count !== '0) begin
         n_err++;
         $display("FAIL drain: left=%0d val_out=%b count=%0d, expected 0 0 0",
                  sb.size(), val_out, count);
      end
   endtask

   task automatic test_reset();
      do_reset(1'b0);
      n_vec++;
      if (val_out !== 1'b0 || dout !== '0 || count !== '0 || full !== 1'b0 ||
          almost_full !== 1'b0 || overflow_err !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state: val=%b dout=%0h count=%0d full=%b af=%b ovf=%b, expected all 0",
                  val_out, dout, count, full, almost_full, overflow_err);
      end
   endtask

   task automatic test_first_word();
      logic seen = 1'b0;
      step(1'b1, PB'(8'hA5), 1'b1);          // write on edge k
      for (int i = 0; i < 2 && !seen; i++) begin
         if (val_out === 1'b1) seen = 1'b1;
         else step(1'b0, '0, 1'b1);
      end
      if (val_out === 1'b1) seen = 1'b1;
      n_vec++;
      if (!seen) begin
         n_err++;
         $display("FAIL first_latency: val_out=%b after edge k+2, expected 1", val_out);
      end
      step(1'b0, '0, 1'b1);                  // the transfer (data via scoreboard)
      n_vec++;
      if (val_out !== 1'b0 || count !== '0 || n_pop != 1) begin
         n_err++;
         $display("FAIL first_after: val_out=%b count=%0d pops=%0d, expected 0 0 1",
                  val_out, count, n_pop);
      end
   endtask

   task automatic test_fill_overflow();
      do_reset(1'b0);
      for (int i = 0; i < DEPTH; i++)
         step(1'b1, PB'(i), 1'b0);
      n_vec++;
      if (full !== 1'b1 || count !== DEPTH || almost_full !== 1'b1) begin
         n_err++;
         $display("FAIL fill_full: full=%b count=%0d af=%b, expected 1 128 1",
                  full, count, almost_full);
      end
      step(1'b1, PB'(DEPTH), 1'b0);          // dropped
      n_vec++;
      if (overflow_err !== 1'b1 || count !== DEPTH) begin
         n_err++;
         $display("FAIL fill_drop: ovf=%b count=%0d, expected 1 128", overflow_err, count);
      end
      for (int i = 0; i < DEPTH; i++) begin
         n_vec++;
         if (val_out !== 1'b1) begin
            n_err++;
            $display("FAIL drain_gap: val_out=%b at word %0d, expected 1", val_out, i);
         end
         step(1'b0, '0, 1'b1);
      end
      n_vec++;
      if (val_out !== 1'b0 || count !== '0 || sb.size() != 0) begin
         n_err++;
         $display("FAIL fill_drained: val_out=%b count=%0d left=%0d, expected 0 0 0",
                  val_out, count, sb.size());
      end
   endtask

   task automatic test_full_same_edge();
      do_reset(1'b0);
      for (int i = 0; i < DEPTH; i++)
         step(1'b1, PB'(i + 1000), 1'b0);
      step(1'b1, PB'(9999), 1'b1);           // write dropped, transfer happens
      n_vec++;
      if (overflow_err !== 1'b1 || count !== (DEPTH - 1) || full !== 1'b0) begin
         n_err++;
         $display("FAIL full_same_edge: ovf=%b count=%0d full=%b, expected 1 127 0",
                  overflow_err, count, full);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      logic [PB-1:0] prev = '0;
      int            steady = 0;
      do_reset(1'b0);
      for (int i = 0; i < 1000; i++) begin
         if (i >= 3) begin
            n_vec++;
            if (val_out !== 1'b1 || (i > 3 && dout !== prev + 1)) begin
               n_err++;
               $display("FAIL b2b_stream: val_out=%b dout=%0h at cycle %0d, expected 1 %0h",
                        val_out, dout, i, prev + 1);
            end
            if (i == 3) steady = m_count;
            n_vec++;
            if (count !== steady) begin
               n_err++;
               $display("FAIL b2b_count: count=%0d at cycle %0d, expected %0d", count, i, steady);
            end
         end
         prev = dout;
         step(1'b1, PB'(i + 5000), 1'b1);
      end
      drain();
   endtask

   task automatic test_random_ready();
      int   sent = 0;
      int   pops0 = n_pop;
      logic w;
      logic r;
      for (int cyc = 0; cyc < 4000 && (sent < 300 || sb.size() != 0 || val_out === 1'b1); cyc++) begin
         w = (sent < 300) && (almost_full === 1'b0);
         r = 1'($urandom_range(0, 1));
         step(w, PB'(sent + 20000), r);
         if (w) sent++;
      end
      n_vec++;
      if (n_pop - pops0 != 300 || overflow_err !== 1'b0 || sb.size() != 0) begin
         n_err++;
         $display("FAIL random_ready: received=%0d ovf=%b left=%0d, expected 300 0 0",
                  n_pop - pops0, overflow_err, sb.size());
      end
   endtask

   task automatic test_reset_midstream();
      int pops0;
      for (int i = 0; i < 50; i++)
         step(1'b1, PB'(i + 777), 1'b0);
      n_vec++;
      if (count !== 50 || val_out !== 1'b1) begin
         n_err++;
         $display("FAIL mid_setup: count=%0d val_out=%b, expected 50 1", count, val_out);
      end
      do_reset(1'b1);
      n_vec++;
      if (val_out !== 1'b0 || dout !== '0 || count !== '0 || full !== 1'b0 ||
          overflow_err !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset: val=%b dout=%0h count=%0d full=%b ovf=%b, expected all 0",
                  val_out, dout, count, full, overflow_err);
      end
      pops0 = n_pop;
      step(1'b1, PB'(1), 1'b1);
      drain();
      n_vec++;
      if (n_pop - pops0 != 1 || last_pop !== PB'(1)) begin
         n_err++;
         $display("FAIL mid_first: pops=%0d word=%0h, expected 1 1", n_pop - pops0, last_pop);
      end
   endtask

   initial begin
      reset = 1'b1;
      wr_en = 1'b0;
      din = '0;
      ready_downward = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_first_word();
      test_fill_overflow();
      test_full_same_edge();
      test_back_to_back();
      test_random_ready();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/stream_out_shell.md
Name: stream_out_shell

Overview:
- Output-side companion of the input stream shell. Sits between an operator's write port and the downstream link toward the next page or network.
- Accepts fire-and-forget writes (wr_en, no per-beat stall), buffers them in a block-RAM FIFO, and drives a registered val_out/ready_downward handshake.
- Gives the operator early backpressure via almost_full, so words already in the operator's pipeline are never lost.

Parameters:
- PAYLOAD_BITS, 128, width of one stream word.
- NUM_BRAM_ADDR_BITS, 7, log2 of FIFO depth; DEPTH = 2**NUM_BRAM_ADDR_BITS.
- ALMOST_FULL_MARGIN, 4, almost_full asserts when free slots <= this value; must be < DEPTH.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- din  in  PAYLOAD_BITS  operator write data.
- wr_en  in  1  operator write strobe; one word per cycle when high.
- almost_full  out  1  registered; operator must stop issuing wr_en within ALMOST_FULL_MARGIN cycles.
- full  out  1  registered; occupancy == DEPTH.
- dout  out  PAYLOAD_BITS  downstream data; 0 whenever val_out=0.
- val_out  out  1  downstream word valid.
- ready_downward  in  1  downstream accepts; a transfer occurs on an edge where val_out && ready_downward.
- count  out  NUM_BRAM_ADDR_BITS+1  registered occupancy: words in RAM + read in flight + word presented.
- overflow_err  out  1  sticky; set by any write dropped because full.

Behaviour:
- Reset: all outputs 0, occupancy 0, FIFO contents discarded, overflow_err cleared. Reset asserted mid-stream drops val_out on the next edge regardless of ready_downward.
- Write acceptance: a word is accepted on an edge with wr_en=1 and full=0.
  - Write while full=1: the word is dropped, count is unchanged, overflow_err <= 1. This holds even if a downstream transfer happens on the same edge, because full is evaluated before that edge.
- count update per edge: +1 on accepted write only; -1 on transfer only; unchanged when both occur or neither occurs.
- full = (count == DEPTH).
- almost_full = (DEPTH - count <= ALMOST_FULL_MARGIN); both flags are registered from the next-state count.
- Output state machine, two states:
  - NODATA: val_out=0, dout=0. If the RAM holds an unread word: issue a RAM read and go to VALDATA. The RAM output register becomes dout; no extra copy register is required.
  - VALDATA: val_out=1, dout=RAM output.
    - ready_downward=0: hold dout and val_out, no read issued.
    - ready_downward=1 and RAM has a word: issue a read, stay in VALDATA. This gives back-to-back transfers at 1 word/cycle.
    - ready_downward=1 and RAM empty: go to NODATA.
- dout must be stable while val_out=1 and ready_downward=0.
- First-word latency: a word written on edge k into an otherwise empty shell has val_out=1 from edge k+2 at the latest.
- Sustained throughput: 1 word/cycle with wr_en and ready_downward both held high.
- Ordering: strict FIFO; no duplication or loss except writes dropped while full.
- Wrap-around: read and write pointers are NUM_BRAM_ADDR_BITS wide and wrap modulo DEPTH. Full and empty are derived from count, never from pointer equality alone.
- Memory: block RAM, 1-cycle read latency, simple dual port. Read-during-write to the same address never occurs, because a slot is read only after count shows it written.

Test Plan:
- Reset, then write 0xA5 (zero-extended) at edge k with ready_downward=1 → val_out=1 and dout=0xA5 by edge k+2; transfer occurs; val_out=0 next edge; count returns 0.
- Hold ready_downward=0 and write 128 words 0..127 → full=1 at count=128; almost_full=1 from count=124; word 128 dropped with overflow_err=1. Then raise ready_downward → 0..127 emerge in order, one per cycle, no gaps.
- wr_en and ready_downward high continuously for 1000 cycles, incrementing data → dout increments by 1 each transfer; count stays constant; no gaps after the first word.
- Toggle ready_downward pseudo-randomly while writing 300 words (operator honours almost_full) → dout stable whenever val_out=1 and ready=0; all 300 words arrive in order; overflow_err=0.
- At count=128, assert wr_en and ready_downward on the same edge → write dropped, overflow_err=1, count=127.
- Assert reset for one cycle with count=50 and val_out=1 → next edge val_out=0, dout=0, count=0, full=0, overflow_err=0; a subsequent write 0x1 emerges first.
